// File: rtl/correlator_lsync_param.sv
// Parametrised long-preamble cross-correlator: sum over taps of conj(sample) * weight,
// with a run-time loadable coefficient set and a pipelined adder tree.
module correlator_lsync_param #(
  parameter int DATA_W = 2,
  parameter int W_W    = 2,
  parameter int N_TAPS = 16,
  parameter int AW     = 4,
  parameter int OUT_W  = DATA_W + W_W + 2 + AW
) (
  input  logic                     CLK,
  input  logic                     s_RST,
  input  logic signed [DATA_W-1:0] I_in,
  input  logic signed [DATA_W-1:0] Q_in,
  input  logic                     input_strobe,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [W_W-1:0]    coef_I,
  input  logic signed [W_W-1:0]    coef_Q,
  output logic                     output_strobe,
  output logic signed [OUT_W-1:0]  I_corr_Out,
  output logic signed [OUT_W-1:0]  Q_corr_Out
);

  localparam int          LVL     = AW;
  localparam logic [AW:0] FULL    = (AW+1)'(N_TAPS);
  localparam logic [AW:0] FULL_M1 = (AW+1)'(N_TAPS - 1);

  logic signed [DATA_W-1:0] r_tapI [N_TAPS];
  logic signed [DATA_W-1:0] r_tapQ [N_TAPS];
  logic signed [W_W-1:0]    r_wI   [N_TAPS];
  logic signed [W_W-1:0]    r_wQ   [N_TAPS];
  logic        [AW:0]       r_fill;
  logic                     r_vIn;
  logic signed [OUT_W-1:0]  r_sI   [LVL+1][N_TAPS];
  logic signed [OUT_W-1:0]  r_sQ   [LVL+1][N_TAPS];
  logic        [LVL:0]      r_v;

  logic w_accept;
  logic w_complete;

  // Flush wins over a coincident strobe, so that sample never reaches the delay line.
  assign w_accept   = input_strobe & ~flush;
  assign w_complete = w_accept & ((r_fill == FULL) | (r_fill == FULL_M1));

  function automatic logic signed [OUT_W-1:0] extD(input logic signed [DATA_W-1:0] v);
    return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [OUT_W-1:0] extW(input logic signed [W_W-1:0] v);
    return {{(OUT_W-W_W){v[W_W-1]}}, v};
  endfunction

  always_ff @(posedge CLK or posedge s_RST) begin
    if (s_RST) begin
      for (int j = 0; j < N_TAPS; j++) begin
        r_tapI[j] <= '0;
        r_tapQ[j] <= '0;
      end
      r_fill <= '0;
      r_vIn  <= 1'b0;
    end else begin
      r_vIn <= w_complete;
      if (flush) begin
        for (int j = 0; j < N_TAPS; j++) begin
          r_tapI[j] <= '0;
          r_tapQ[j] <= '0;
        end
        r_fill <= '0;
      end else if (input_strobe) begin
        for (int j = 0; j < N_TAPS - 1; j++) begin
          r_tapI[j] <= r_tapI[j+1];
          r_tapQ[j] <= r_tapQ[j+1];
        end
        r_tapI[N_TAPS-1] <= I_in;
        r_tapQ[N_TAPS-1] <= Q_in;
        if (r_fill != FULL) r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge s_RST) begin
    if (s_RST) begin
      for (int j = 0; j < N_TAPS; j++) begin
        r_wI[j] <= '0;
        r_wQ[j] <= '0;
      end
    end else if (coef_we) begin
      r_wI[coef_addr] <= coef_I;
      r_wQ[coef_addr] <= coef_Q;
    end
  end

  // Level 0 holds the per-tap products; level l holds N_TAPS>>l partial sums.
  always_ff @(posedge CLK or posedge s_RST) begin
    if (s_RST) begin
      for (int l = 0; l <= LVL; l++) begin
        for (int k = 0; k < N_TAPS; k++) begin
          r_sI[l][k] <= '0;
          r_sQ[l][k] <= '0;
        end
      end
      r_v <= '0;
    end else begin
      for (int j = 0; j < N_TAPS; j++) begin
        r_sI[0][j] <= extD(r_tapI[j]) * extW(r_wI[j]) + extD(r_tapQ[j]) * extW(r_wQ[j]);
        r_sQ[0][j] <= extD(r_tapI[j]) * extW(r_wQ[j]) - extD(r_tapQ[j]) * extW(r_wI[j]);
      end
      for (int l = 1; l <= LVL; l++) begin
        for (int k = 0; k < N_TAPS; k++) begin
          if (k < (N_TAPS >> l)) begin
            r_sI[l][k] <= r_sI[l-1][2*k] + r_sI[l-1][2*k+1];
            r_sQ[l][k] <= r_sQ[l-1][2*k] + r_sQ[l-1][2*k+1];
          end
        end
      end
      if (flush) r_v <= '0;
      else       r_v <= {r_v[LVL-1:0], r_vIn};
    end
  end

  always_ff @(posedge CLK or posedge s_RST) begin
    if (s_RST) begin
      output_strobe <= 1'b0;
      I_corr_Out    <= '0;
      Q_corr_Out    <= '0;
    end else begin
      output_strobe <= r_v[LVL] & ~flush;
      if (r_v[LVL] && !flush) begin
        I_corr_Out <= r_sI[LVL][0];
        Q_corr_Out <= r_sQ[LVL][0];
      end
    end
  end

endmodule

// File: tb/tb_correlator_lsync_param.sv
// Bench for correlator_lsync_param: correlation model compared every cycle, plus
// hand-computed checks of latency, values, flush and reset behaviour.
module tb_correlator_lsync_param;
  localparam int DATA_W = 2;
  localparam int W_W    = 2;
  localparam int N_TAPS = 16;
  localparam int AW     = 4;
  localparam int OUT_W  = 10;
  localparam int LAT    = 6;

  logic                     CLK = 1'b0;
  logic                     s_RST = 1'b1;
  logic signed [DATA_W-1:0] I_in = '0;
  logic signed [DATA_W-1:0] Q_in = '0;
  logic                     input_strobe = 1'b0;
  logic                     flush = 1'b0;
  logic                     coef_we = 1'b0;
  logic        [AW-1:0]     coef_addr = '0;
  logic signed [W_W-1:0]    coef_I = '0;
  logic signed [W_W-1:0]    coef_Q = '0;
  logic                     output_strobe;
  logic signed [OUT_W-1:0]  I_corr_Out;
  logic signed [OUT_W-1:0]  Q_corr_Out;

  correlator_lsync_param #(
    .DATA_W(DATA_W), .W_W(W_W), .N_TAPS(N_TAPS), .AW(AW), .OUT_W(OUT_W)
  ) dut (
    .CLK(CLK), .s_RST(s_RST), .I_in(I_in), .Q_in(Q_in),
    .input_strobe(input_strobe), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_I(coef_I), .coef_Q(coef_Q),
    .output_strobe(output_strobe), .I_corr_Out(I_corr_Out), .Q_corr_Out(Q_corr_Out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int due;
    int re;
    int im;
  } expT;

  expT  q[$];
  int   cyc = 0;
  int   tI[N_TAPS];
  int   tQ[N_TAPS];
  int   wI[N_TAPS];
  int   wQ[N_TAPS];
  int   fill = 0;
  logic expStb = 1'b0;
  int   expI = 0;
  int   expQ = 0;

  int nVec = 0;
  int nFail = 0;
  int strbCount = 0;
  int nzCount = 0;
  int nzI = 0;
  int nzQ = 0;

  // Model: every completing sample yields one result, due LAT edges after acceptance.
  always @(posedge CLK or posedge s_RST) begin : model
    int re, im;
    if (s_RST) begin
      for (int j = 0; j < N_TAPS; j++) begin
        tI[j] = 0; tQ[j] = 0; wI[j] = 0; wQ[j] = 0;
      end
      fill = 0;
      q.delete();
      expStb = 1'b0;
      expI = 0;
      expQ = 0;
    end else begin
      cyc++;
      if (coef_we) begin
        wI[int'(coef_addr)] = int'(coef_I);
        wQ[int'(coef_addr)] = int'(coef_Q);
      end
      if (flush) begin
        for (int j = 0; j < N_TAPS; j++) begin
          tI[j] = 0; tQ[j] = 0;
        end
        fill = 0;
        q.delete();
      end else if (input_strobe) begin
        for (int j = 0; j < N_TAPS - 1; j++) begin
          tI[j] = tI[j+1];
          tQ[j] = tQ[j+1];
        end
        tI[N_TAPS-1] = int'(I_in);
        tQ[N_TAPS-1] = int'(Q_in);
        if (fill < N_TAPS) fill++;
        if (fill == N_TAPS) begin
          re = 0;
          im = 0;
          for (int j = 0; j < N_TAPS; j++) begin
            re += tI[j] * wI[j] + tQ[j] * wQ[j];
            im += tI[j] * wQ[j] - tQ[j] * wI[j];
          end
          q.push_back('{cyc + LAT, re, im});
        end
      end
      expStb = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        expStb = 1'b1;
        expI = q[0].re;
        expQ = q[0].im;
        void'(q.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge CLK);
      checkOutput("strobe", int'(output_strobe), int'(expStb));
      checkOutput("I_corr", int'(I_corr_Out), expI);
      checkOutput("Q_corr", int'(Q_corr_Out), expQ);
      if (output_strobe === 1'b1) begin
        strbCount++;
        if (I_corr_Out != 0 || Q_corr_Out != 0) begin
          nzCount++;
          nzI = int'(I_corr_Out);
          nzQ = int'(Q_corr_Out);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic stb, input int xi, input int xq, input logic fl);
    input_strobe = stb;
    I_in = DATA_W'(xi);
    Q_in = DATA_W'(xq);
    flush = fl;
    @(posedge CLK);
    #1;
    input_strobe = 1'b0;
    flush = 1'b0;
  endtask

  task automatic loadCoef(input int a, input int wi, input int wq);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_I = W_W'(wi);
    coef_Q = W_W'(wq);
    @(posedge CLK);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic loadAll(input int wi, input int wq);
    for (int a = 0; a < N_TAPS; a++) loadCoef(a, wi, wq);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int n0;
    fork
      compareLoop();
    join_none

    idle(3);
    checkOutput("reset_strobe", int'(output_strobe), 0);
    checkOutput("reset_I", int'(I_corr_Out), 0);
    checkOutput("reset_Q", int'(Q_corr_Out), 0);
    s_RST = 1'b0;
    idle(2);

    // Weights (1,0), samples (1,1): each tap gives (1,-1).
    loadAll(1, 0);
    s0 = strbCount;
    for (int i = 0; i < N_TAPS; i++) applyStimulus(1'b1, 1, 1, 1'b0);
    repeat (LAT) @(negedge CLK);
    checkOutput("s1_no_early_strobe", int'(output_strobe), 0);
    checkOutput("s1_none_before_16th", strbCount - s0, 0);
    @(negedge CLK);
    checkOutput("s1_first_strobe", int'(output_strobe), 1);
    checkOutput("s1_first_I", int'(I_corr_Out), 16);
    checkOutput("s1_first_Q", int'(Q_corr_Out), -16);
    idle(10);

    // Most negative operands everywhere: 16 * (4+4) = 128, imaginary cancels.
    loadAll(-2, -2);
    s0 = strbCount;
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, -2, -2, 1'b0);
    idle(10);
    checkOutput("s2_count", strbCount - s0, 24);
    checkOutput("s2_I", int'(I_corr_Out), 128);
    checkOutput("s2_Q", int'(Q_corr_Out), 0);

    // Impulse (1,1) against weight[3]=(1,-1): conj gives (0,-2).
    applyStimulus(1'b0, 0, 0, 1'b1);
    loadAll(0, 0);
    loadCoef(3, 1, -1);
    s0 = strbCount;
    n0 = nzCount;
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, (i == 6) ? 1 : 0, (i == 6) ? 1 : 0, 1'b0);
    idle(10);
    checkOutput("s3_count", strbCount - s0, 9);
    checkOutput("s3_nonzero_count", nzCount - n0, 1);
    checkOutput("s3_impulse_I", nzI, 0);
    checkOutput("s3_impulse_Q", nzQ, -2);

    // Gapped strobes, one every three clocks.
    applyStimulus(1'b0, 0, 0, 1'b1);
    loadAll(1, 0);
    s0 = strbCount;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1, 1, 1'b0);
      idle(2);
    end
    idle(8);
    checkOutput("s4_count", strbCount - s0, 5);
    checkOutput("s4_I", int'(I_corr_Out), 16);
    checkOutput("s4_Q", int'(Q_corr_Out), -16);

    // Flush kills in-flight results; flush with strobe drops that sample.
    s0 = strbCount;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1, 1, 1'b0);
    applyStimulus(1'b1, -1, 1, 1'b1);
    for (int i = 0; i < N_TAPS - 1; i++) applyStimulus(1'b1, 1, 1, 1'b0);
    idle(10);
    checkOutput("s5_none_after_15", strbCount - s0, 0);
    applyStimulus(1'b1, 1, 1, 1'b0);
    idle(10);
    checkOutput("s5_one_after_16", strbCount - s0, 1);
    checkOutput("s5_I", int'(I_corr_Out), 16);
    checkOutput("s5_Q", int'(Q_corr_Out), -16);

    // Asynchronous reset with results in flight.
    loadAll(-2, -2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, -2, -2, 1'b0);
    #2;
    s_RST = 1'b1;
    #1;
    checkOutput("s6_async_strobe", int'(output_strobe), 0);
    checkOutput("s6_async_I", int'(I_corr_Out), 0);
    checkOutput("s6_async_Q", int'(Q_corr_Out), 0);
    idle(3);
    s_RST = 1'b0;
    s0 = strbCount;
    idle(12);
    checkOutput("s6_no_stale_strobe", strbCount - s0, 0);
    checkOutput("s6_hold_I", int'(I_corr_Out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/correlator_lsync_param.md
Name: correlator_lsync_param

Overview:
- Parametrised long-preamble cross-correlator, the next generation of the fixed 16-tap, 2-bit L-sync correlator.
- Correlates a strobed complex sample stream against a run-time loadable complex coefficient set, computed as the sum of conj(sample) × weight over N_TAPS taps.
- Pipelined adder tree with a matched output strobe; outputs are suppressed until the delay line is full.
- Sits between the quantiser and the L-sync peak detector in the sync chain.

Parameters:
- DATA_W, 2, signed bit width of I/Q input samples
- W_W, 2, signed bit width of I/Q coefficients
- N_TAPS, 16, number of taps; must be a power of two, 2..64
- AW, 4, coefficient address width; equals clog2(N_TAPS)
- OUT_W, DATA_W+W_W+2+AW, signed output width; full precision, no overflow possible

Ports:
- CLK, in, 1, single clock
- s_RST, in, 1, asynchronous active-high reset
- I_in, in, DATA_W, signed sample real part
- Q_in, in, DATA_W, signed sample imaginary part
- input_strobe, in, 1, sample valid; sampled every CLK edge
- flush, in, 1, synchronous clear of the delay line and fill count
- coef_we, in, 1, coefficient write enable
- coef_addr, in, AW, tap index to write
- coef_I, in, W_W, signed coefficient real part
- coef_Q, in, W_W, signed coefficient imaginary part
- output_strobe, out, 1, one-cycle pulse marking a valid correlation output
- I_corr_Out, out, OUT_W, correlation real part
- Q_corr_Out, out, OUT_W, correlation imaginary part

Behaviour:
- Reset (async assert, release synchronous to CLK): clears delay line, coefficients, fill counter, all pipeline registers, output_strobe, I_corr_Out and Q_corr_Out to 0.
- Reset mid-operation clears all in-flight results; no output_strobe is issued for them.

Delay line:
- On a CLK edge with input_strobe=1, taps shift toward index 0 and tap N_TAPS-1 takes the new sample. Tap 0 is the oldest sample.
- The delay line holds when input_strobe=0.

Fill counter:
- Saturates at N_TAPS and increments on each accepted sample.
- A sample is "valid-complete" when the fill count after the shift equals N_TAPS, i.e. from the N_TAPS-th sample after reset or flush onward.

Flush:
- Zeroes the taps and the fill counter, and kills the valid bits of in-flight pipeline entries.
- If flush and input_strobe occur in the same cycle, flush wins and the sample is dropped.

Arithmetic:
- Per tap j: I_j = xI*wI + xQ*wQ and Q_j = xI*wQ - xQ*wI.
- Operands are sign-extended before multiply and negate, so the most negative input value is handled exactly.
- Results are summed at full precision into OUT_W bits; there is no saturation or rounding.

Pipeline:
- Stage P0 registers the per-tap products.
- Then clog2(N_TAPS) registered binary adder-tree levels follow.
- The pipeline advances every clock, independent of the strobe.
- A valid bit travels alongside the data.

Latency:
- output_strobe asserts exactly LAT = 2 + clog2(N_TAPS) clocks after the CLK edge that accepted the completing sample (6 for N_TAPS=16).
- Results are in the same order as the samples; back-to-back strobes give back-to-back outputs.

Output hold:
- I_corr_Out and Q_corr_Out update only when output_strobe=1 and hold their last value otherwise.

Coefficients:
- coef_we writes tap coef_addr at the CLK edge.
- A written coefficient first affects products computed from the delay-line state on the following cycle; results already in flight are unaffected.
- A write to a given address in the same cycle as input_strobe does not delay the sample.

Test Plan:
- Reset, then load all weights to (1,0) and feed 16 strobes of (1,1) -> first output_strobe occurs 6 clocks after the 16th strobe with I=16, Q=-16; no strobe occurs after strobes 1-15.
- All weights (-2,-2), all samples (-2,-2), continuous strobe -> steady-state I=128, Q=0; there is no wrap.
- Impulse: weight[3]=(1,-1), other weights 0, samples all zero except one sample (1,1) -> exactly one output with I=0, Q=-2, on the output whose tap 3 holds the impulse.
- Gapped strobe (1 strobe every 3 clocks) with the same data as the first scenario -> identical values; output_strobe spacing matches the input spacing; outputs hold between pulses.
- Flush asserted together with input_strobe after 10 samples -> that sample is dropped; in-flight strobes are killed; the next output appears only after 16 new samples.
- Async reset asserted mid-stream with outputs pending -> outputs go to 0 immediately and no stale output_strobe appears after release.
